apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles with PREADY low before abort; legal range 1..65535.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  command present.
REQ-007 SHALL have port req_ready  output  1  command accepted when high with req_valid.
REQ-008 SHALL have port req_write  input  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  input  ADDR_W  target address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  transfer aborted by timeout.
REQ-015 SHALL have ports PADDR (output, ADDR_W), PWDATA (output, DATA_W), PWRITE, PSELx, PENABLE (outputs, 1), PRDATA (input, DATA_W), PREADY (input, 1): APB master side, driving a slave such as the UART APB block.

Function
REQ-016 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake in IDLE latches req_write/req_addr/req_wdata and moves to SETUP next cycle.
REQ-018 SETUP SHALL last exactly one cycle with PSELx=1, PENABLE=0, then move to ACCESS.
REQ-019 ACCESS SHALL drive PSELx=1, PENABLE=1 and stay until PREADY is sampled high or timeout occurs.
REQ-020 PADDR, PWDATA, PWRITE SHALL be stable from SETUP through the final ACCESS cycle, and SHALL hold their last values afterwards.
REQ-021 On PREADY=1 in ACCESS: capture PRDATA into rsp_rdata if read (0 if write), rsp_err=0, go to RESP; PSELx=PENABLE=0 next cycle.
REQ-022 SHALL maintain a 16-bit wait counter, cleared on SETUP entry, incremented each ACCESS cycle with PREADY=0.
REQ-023 When the counter equals TIMEOUT and PREADY=0: abort, rsp_rdata=0, rsp_err=1, go to RESP, PSELx=PENABLE=0 next cycle.
REQ-024 PREADY=1 in the cycle the counter equals TIMEOUT SHALL complete normally (PREADY wins).
REQ-025 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then go to IDLE next cycle; no new request is accepted before that.
REQ-026 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3 with zero-wait slave; back-to-back throughput one transfer per 4 cycles with rsp_ready tied high.
REQ-027 PSELx and PENABLE SHALL never be high outside SETUP/ACCESS; PENABLE SHALL never be high without PSELx.

Reset
REQ-028 reset=1 SHALL, on the next edge, force IDLE and set PSELx, PENABLE, PWRITE, rsp_valid, rsp_err to 0, PADDR, PWDATA, rsp_rdata and wait counter to 0, req_ready to 0 while reset is high.
REQ-029 Reset in SETUP, ACCESS or RESP SHALL drop the transfer/response with no later rsp_valid for it; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-030 Zero-wait write: req addr 0x0000_0004, wdata 0x0000_0041, write -> SETUP then ACCESS with PWRITE=1, PWDATA=0x41; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-031 Read with 3 wait states: slave PRDATA=0x0000_00A5, PREADY high on 4th ACCESS cycle -> PADDR stable 5 cycles, rsp_rdata=0xA5, rsp_err=0.
REQ-032 Timeout: TIMEOUT=4, PREADY stuck 0 -> ACCESS lasts exactly 5 cycles, then rsp_err=1, rsp_rdata=0, PSELx=0.
REQ-033 Boundary: TIMEOUT=4, PREADY=1 in 5th ACCESS cycle -> normal completion, rsp_err=0.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles with req_valid held 1 -> rsp_valid held, req_ready=0, no second SETUP until cycle after rsp_ready=1.
REQ-035 Reset mid-ACCESS: assert reset during wait state -> next cycle PSELx=PENABLE=0, rsp_valid never asserted for that command, req_ready=1 after reset release.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB master-side signals for apb_master.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSELx;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one APB transfer, one response out,
// with a wait-state timeout that aborts a transfer whose slave never raises PREADY.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic [15:0]       wait_q;
  logic [15:0]       wait_d;

  assign wait_d = wait_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready rises one cycle after reset or a consumed response
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            paddr_q     <= bus.req_addr;
            pwdata_q    <= bus.req_wdata;
            pwrite_q    <= bus.req_write;
            psel_q      <= 1'b1;
            wait_q      <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a ready in the timeout cycle still completes
          if (bus.PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
            state_q     <= RESP;
          end else if (wait_q == TMO) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            wait_q <= wait_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a stimulus thread plays the APB slave and pushes expected
// responses; a monitor pops and compares them whenever a response handshake occurs.
module tb_apb_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor and bus-protocol guard
  always @(negedge clk) begin
    if (!reset) begin
      chk("penable_without_psel", {31'b0, bus.PENABLE & ~bus.PSELx}, 32'd0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  // One full transfer. waits = PREADY-low ACCESS cycles before PREADY rises; bp = RESP
  // cycles held with rsp_ready low (a new request is held on req_valid meanwhile).
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prdata, input int exp_acc,
                          input logic [31:0] exp_rdata, input logic exp_err, input int bp);
    int   acc;
    int   guard;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (bp == 0);
    bus.PREADY    = 1'b0;
    bus.PRDATA    = prdata;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    tick();
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    bus.req_valid = 1'b0;
    chk("setup_psel", {31'b0, bus.PSELx}, 32'd1);
    chk("setup_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("setup_paddr", bus.PADDR, addr);
    chk("setup_pwrite", {31'b0, bus.PWRITE}, {31'b0, wr});
    if (wr) chk("setup_pwdata", bus.PWDATA, wdata);
    chk("setup_req_ready", {31'b0, bus.req_ready}, 32'd0);
    acc = 0;
    guard = 0;
    tick();
    while (bus.PSELx && bus.PENABLE && guard < 100) begin
      acc++;
      guard++;
      chk("access_paddr", bus.PADDR, addr);
      bus.PREADY = (acc == waits + 1);
      tick();
    end
    bus.PREADY = 1'b0;
    chk("access_cycles", acc, exp_acc);
    chk("resp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("resp_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("resp_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("resp_paddr_hold", bus.PADDR, addr);
    if (bp > 0) begin
      bus.req_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("bp_rdata", bus.rsp_rdata, exp_rdata);
        chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("bp_psel", {31'b0, bus.PSELx}, 32'd0);
        tick();
      end
      bus.rsp_ready = 1'b1;
    end
    tick();
    chk("idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("idle_psel", {31'b0, bus.PSELx}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    tick();
    tick();
    chk("rst_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("rst_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // zero-wait write, read with 3 waits, timeout, PREADY on the timeout cycle
    run_xfer(1'b1, 32'h0000_0004, 32'h0000_0041, 0,  32'h0000_0055, 1, 32'h0, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0010, 32'h0,         3,  32'h0000_00A5, 4, 32'h0000_00A5, 1'b0, 0);
    run_xfer(1'b0, 32'h0000_0020, 32'h0,         99, 32'h0000_0077, 5, 32'h0, 1'b1, 0);
    run_xfer(1'b0, 32'h0000_0024, 32'h0,         4,  32'h0000_5A5A, 5, 32'h0000_5A5A, 1'b0, 0);
    run_xfer(1'b1, 32'h0000_0028, 32'h0000_CAFE, 99, 32'h0000_0001, 5, 32'h0, 1'b1, 0);

    // backpressure, then the held request goes out right after the response is consumed
    run_xfer(1'b0, 32'h0000_0008, 32'h0,         0,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 10);
    run_xfer(1'b1, 32'h0000_000C, 32'h1234_5678, 2,  32'h0000_0009, 3, 32'h0, 1'b0, 0);

    // reset while waiting in ACCESS drops the transfer
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0030;
    bus.rsp_ready = 1'b1;
    bus.PREADY    = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_setup_psel", {31'b0, bus.PSELx}, 32'd1);
    tick();
    tick();
    chk("mid_access_penable", {31'b0, bus.PENABLE}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("mid_rst_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("dropped_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      tick();
    end

    run_xfer(1'b0, 32'h0000_0040, 32'h0,         1,  32'h0000_003C, 2, 32'h0000_003C, 1'b0, 0);

    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
